pool_window_sequencer: RTL and testbench
========================================

Name: pool_window_sequencer

Overview:
Controller that runs the 3x3 absolute-deviation max-pooling kernel over a feature map held in a single-port input BRAM.
- Walks non-overlapping 3x3 windows in raster order.
- Fetches nine pixels per window and packs them into the kernel's 72-bit window bus.
- Captures the kernel's 8-bit result and writes it to an output BRAM.
- Sits between the BRAM wrappers and the pooling kernel; a top-level start/done handshake drives it.

Parameters:
DWIDTH, 8, pixel width (window bus is 9*DWIDTH).
IMG_W, 9, input image width in pixels.
IMG_H, 9, input image height in pixels.
ADDR_W, 10, BRAM address width for both input and output.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high from the first FETCH cycle through the DONE cycle
done  out  1  one-cycle pulse in the DONE state
rd_en  out  1  input BRAM read enable
rd_addr  out  ADDR_W  input BRAM read address
rd_data  in  DWIDTH  input BRAM data, valid 1 cycle after rd_en
win_data  out  9*DWIDTH  packed window to kernel
win_valid  out  1  window complete and stable (EVAL cycle)
pool_result  in  DWIDTH  combinational kernel output
wr_en  out  1  output BRAM write strobe
wr_addr  out  ADDR_W  output address = window index
wr_data  out  DWIDTH  registered kernel result

Behaviour:
- Reset (rst_n low, any time, mid-frame included): state=IDLE immediately; all outputs, window register and counters cleared to 0. Outstanding reads are discarded.
- Output grid: OW=IMG_W/3, OH=IMG_H/3 (floor). Trailing rows/columns that do not fill a window are never read.
- Window (wr, wc) top-left pixel: (3*wr, 3*wc). Slot k=r*3+c has address (3*wr+r)*IMG_W + 3*wc+c and lands in win_data[k*DWIDTH +: DWIDTH].
- FSM states: IDLE, FETCH, DRAIN, EVAL, WRITE, DONE.
- IDLE -> FETCH on start=1. start in any other state is ignored.
- FETCH: 9 cycles, k=0..8. rd_en=1 with the slot-k address. The data for slot k-1 is written into the window register each cycle.
- DRAIN: 1 cycle. rd_en=0; slot 8 captured.
- EVAL: win_valid=1; wr_data <= pool_result at the end of the cycle.
- WRITE: wr_en=1 for one cycle; wr_addr=wr*OW+wc.
  - If this is not the last window: advance wc, wrapping to 0 and incrementing wr at OW-1; go to FETCH.
  - If it is the last window: go to DONE.
- DONE: done=1 and busy=1 for 1 cycle, then IDLE.
- Timing: 12 cycles per window. With the first FETCH cycle numbered 1, window w writes in cycle 12w+12, and DONE is cycle 12*OW*OH+1.
- win_data holds its value outside EVAL; only the EVAL cycle is meaningful.
- Degenerate case: OW=0 or OH=0 gives IDLE -> DONE directly; one done pulse, no reads, no writes.

Optional Feature:
POOL_PERF_EN:
- Defined: adds output perf_cycles (16 bits). It clears on accepted start, increments every busy cycle, saturates at 0xFFFF, and holds after done until the next start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pool_pkg: state enum; KSIZE=3; WIN_PIX=9; CYC_PER_WIN=12; the slot-index-to-bit-offset helper function.
- Sub-module pool_addr_gen: holds the wr/wc/r/c counters and computes rd_addr/wr_addr. It has step and clear inputs plus last_slot and last_window flags.
- The FSM, window register and output registers stay in pool_window_sequencer.

Test Plan:
- Pixel value = address (9x9, BRAM model with 1-cycle latency), start pulse. Expect 9 writes, wr_addr 0..8, each wr_data=1 (adjacent-column difference 1). done in cycle 109; busy low in cycle 110.
- Window 0 from a checkerboard of 0/200: win_data in EVAL matches the packing order. Expect wr_data=200 at wr_addr 0.
- Assert start again in cycles 5 and 50 while busy. Expect no restart, still 9 writes, a single done.
- Drop rst_n in cycle 30 (mid-FETCH of window 2), release, then start. Outputs go 0 asynchronously, the fresh frame begins at wr_addr 0, and all 9 results are correct.
- IMG_W=10, IMG_H=11: the read-address log never contains column 9 or rows 9-10. Expect 9 writes and done in cycle 109.
- With POOL_PERF_EN: perf_cycles=109 after done and holds. A second start clears it to 0 then counts to 109 again.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the 3x3 pooling window sequencer.
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EVAL,
    WRITE,
    DONE
  } state_t;

  localparam int KSIZE       = 3;
  localparam int WIN_PIX     = KSIZE * KSIZE;
  localparam int CYC_PER_WIN = WIN_PIX + 3;

  // Bit offset of window slot k inside the packed window bus.
  function automatic int slot_offset(input int slot, input int dwidth);
    return slot * dwidth;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/slot counters and the input/output BRAM address arithmetic.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic              advance,
  output logic              last_slot,
  output logic              last_window,
  output logic [3:0]        slot,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int OW = IMG_W / KSIZE;
  localparam int OH = IMG_H / KSIZE;

  logic [ADDR_W-1:0] wr_q, wc_q;
  logic [1:0]        r_q, c_q;

  // NOTE: every flop here uses <= so all counters update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      wc_q <= '0;
      r_q  <= '0;
      c_q  <= '0;
    end else if (clear) begin
      wr_q <= '0;
      wc_q <= '0;
      r_q  <= '0;
      c_q  <= '0;
    end else begin
      if (step) begin
        if (c_q == 2'(KSIZE - 1)) begin
          c_q <= '0;
          r_q <= (r_q == 2'(KSIZE - 1)) ? 2'd0 : r_q + 2'd1;
        end else begin
          c_q <= c_q + 2'd1;
        end
      end
      if (advance) begin
        if (wc_q == ADDR_W'(OW - 1)) begin
          wc_q <= '0;
          wr_q <= wr_q + ADDR_W'(1);
        end else begin
          wc_q <= wc_q + ADDR_W'(1);
        end
      end
    end
  end

  assign last_slot   = (r_q == 2'(KSIZE - 1)) && (c_q == 2'(KSIZE - 1));
  assign last_window = (wr_q == ADDR_W'(OH - 1)) && (wc_q == ADDR_W'(OW - 1));
  assign slot        = 4'(32'(r_q) * KSIZE + 32'(c_q));

  // Pixel (3*wr + r, 3*wc + c) in a row-major image of width IMG_W.
  assign rd_addr = ADDR_W'((32'(wr_q) * KSIZE + 32'(r_q)) * IMG_W
                           + 32'(wc_q) * KSIZE + 32'(c_q));
  assign wr_addr = ADDR_W'(32'(wr_q) * OW + 32'(wc_q));

endmodule

// File: rtl/pool_window_sequencer.sv
// Sequencer feeding 3x3 windows from input BRAM to the pooling kernel and storing results.
// Optional POOL_PERF_EN adds a saturating 16-bit busy-cycle counter output (perf_cycles).
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DWIDTH-1:0]         rd_data,
  output logic [WIN_PIX*DWIDTH-1:0] win_data,
  output logic                      win_valid,
  input  logic [DWIDTH-1:0]         pool_result,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
`ifdef POOL_PERF_EN
  output logic [DWIDTH-1:0]         wr_data,
  output logic [15:0]               perf_cycles
`else
  output logic [DWIDTH-1:0]         wr_data
`endif
);

  localparam bit EMPTY_GRID = ((IMG_W / KSIZE) == 0) || ((IMG_H / KSIZE) == 0);

  state_t state_q, state_d;

  logic                      clear, step, advance;
  logic                      last_slot, last_window;
  logic [3:0]                slot, cap_slot_q;
  logic                      cap_en_q;
  logic [WIN_PIX*DWIDTH-1:0] win_q;
  logic [DWIDTH-1:0]         wr_data_q;

  assign clear = (state_q == IDLE) && start;

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .step       (step),
    .advance    (advance),
    .last_slot  (last_slot),
    .last_window(last_window),
    .slot       (slot),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: assigning a default before the case keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EMPTY_GRID ? DONE : FETCH;
      FETCH:   if (last_slot) state_d = DRAIN;
      DRAIN:   state_d = EVAL;
      EVAL:    state_d = WRITE;
      WRITE:   state_d = last_window ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    step      = 1'b0;
    win_valid = 1'b0;
    wr_en     = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      IDLE:  busy = 1'b0;
      FETCH: begin
        rd_en = 1'b1;
        step  = 1'b1;
      end
      EVAL:  win_valid = 1'b1;
      WRITE: begin
        wr_en   = 1'b1;
        advance = !last_window;
      end
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // BRAM data returns one cycle after the read, so remember which slot it belongs to.
  // NOTE: the window register is only 72 flops, so it is reset; large RAM arrays would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en_q   <= 1'b0;
      cap_slot_q <= '0;
      win_q      <= '0;
    end else begin
      cap_en_q   <= rd_en;
      cap_slot_q <= slot;
      if (cap_en_q) win_q[slot_offset(int'(cap_slot_q), DWIDTH) +: DWIDTH] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wr_data_q <= '0;
    else if (state_q == EVAL)  wr_data_q <= pool_result;
  end

  assign win_data = win_q;
  assign wr_data  = wr_data_q;

`ifdef POOL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              perf_q <= '0;
    else if (clear)                          perf_q <= '0;
    else if (busy && (perf_q != 16'hFFFF))   perf_q <= perf_q + 16'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench: 9x9 frames, 10x11 trailing-pixel frame, empty grid, restart and mid-frame reset.
module tb_pool_window_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Kernel model: largest absolute difference between horizontally adjacent pixels.
  function automatic logic [7:0] kern(input logic [71:0] w);
    logic [7:0] m, a, b, d;
    m = 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++) begin
        a = w[(r*3+c)*8 +: 8];
        b = w[(r*3+c+1)*8 +: 8];
        d = (a > b) ? a - b : b - a;
        if (d > m) m = d;
      end
    return m;
  endfunction

  // ---------------- instance A: 9x9 ----------------
  logic        start_a = 1'b0, busy_a, done_a, rd_en_a, win_valid_a, wr_en_a;
  logic [9:0]  rd_addr_a, wr_addr_a;
  logic [7:0]  rd_data_a = 8'd0, wr_data_a, pool_result_a;
  logic [71:0] win_data_a;
  logic [7:0]  mem_a [0:1023];
`ifdef POOL_PERF_EN
  logic [15:0] perf_a, perf_b, perf_z;
`endif

  pool_window_sequencer #(.DWIDTH(8), .IMG_W(9), .IMG_H(9), .ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .win_data(win_data_a), .win_valid(win_valid_a), .pool_result(pool_result_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a),
`ifdef POOL_PERF_EN
    .wr_data(wr_data_a), .perf_cycles(perf_a)
`else
    .wr_data(wr_data_a)
`endif
  );

  assign pool_result_a = kern(win_data_a);
  always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];

  // ---------------- instance B: 10x11 ----------------
  logic        start_b = 1'b0, busy_b, done_b, rd_en_b, win_valid_b, wr_en_b;
  logic [9:0]  rd_addr_b, wr_addr_b;
  logic [7:0]  rd_data_b = 8'd0, wr_data_b, pool_result_b;
  logic [71:0] win_data_b;

  pool_window_sequencer #(.DWIDTH(8), .IMG_W(10), .IMG_H(11), .ADDR_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .win_data(win_data_b), .win_valid(win_valid_b), .pool_result(pool_result_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b),
`ifdef POOL_PERF_EN
    .wr_data(wr_data_b), .perf_cycles(perf_b)
`else
    .wr_data(wr_data_b)
`endif
  );

  assign pool_result_b = kern(win_data_b);
  always @(posedge clk) if (rd_en_b) rd_data_b <= 8'(rd_addr_b);

  // ---------------- instance Z: empty output grid ----------------
  logic        start_z = 1'b0, busy_z, done_z, rd_en_z, win_valid_z, wr_en_z;
  logic [9:0]  rd_addr_z, wr_addr_z;
  logic [7:0]  wr_data_z;
  logic [71:0] win_data_z;

  pool_window_sequencer #(.DWIDTH(8), .IMG_W(2), .IMG_H(9), .ADDR_W(10)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .busy(busy_z), .done(done_z),
    .rd_en(rd_en_z), .rd_addr(rd_addr_z), .rd_data(8'd0),
    .win_data(win_data_z), .win_valid(win_valid_z), .pool_result(8'd0),
    .wr_en(wr_en_z), .wr_addr(wr_addr_z),
`ifdef POOL_PERF_EN
    .wr_data(wr_data_z), .perf_cycles(perf_z)
`else
    .wr_data(wr_data_z)
`endif
  );

  // ---------------- monitors ----------------
  int          wa_addr[$], wa_data[$], wa_cyc[$];
  int          done_cnt_a, done_cyc_a, win_cyc_a;
  bit          win_seen_a;
  logic [71:0] win_first_a;
  logic        busy_log_a [0:255];
  int          perf_log_a [0:255];
  int          wr_cnt_b, rd_cnt_b, bad_rd_b, done_cnt_b, done_cyc_b, last_data_b;
  int          wr_cnt_z, rd_cnt_z, done_cnt_z, done_cyc_z;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rel >= 0 && rel < 256) begin
      busy_log_a[rel] = busy_a;
`ifdef POOL_PERF_EN
      perf_log_a[rel] = int'(perf_a);
`endif
    end
    if (wr_en_a) begin
      wa_addr.push_back(int'(wr_addr_a));
      wa_data.push_back(int'(wr_data_a));
      wa_cyc.push_back(rel);
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = rel;
    end
    if (win_valid_a && !win_seen_a) begin
      win_seen_a  = 1'b1;
      win_first_a = win_data_a;
      win_cyc_a   = rel;
    end
    if (rd_en_b) begin
      rd_cnt_b++;
      if ((rd_addr_b % 10) == 9 || (rd_addr_b / 10) >= 9) bad_rd_b++;
    end
    if (wr_en_b) begin
      if (int'(wr_addr_b) != wr_cnt_b) bad_rd_b += 100;
      wr_cnt_b++;
      last_data_b = int'(wr_data_b);
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = rel;
    end
    if (rd_en_z) rd_cnt_z++;
    if (wr_en_z) wr_cnt_z++;
    if (done_z) begin
      done_cnt_z++;
      done_cyc_z = rel;
    end
  end

  task automatic clear_logs();
    wa_addr.delete();
    wa_data.delete();
    wa_cyc.delete();
    done_cnt_a = 0; done_cyc_a = -1; win_cyc_a = -1; win_seen_a = 1'b0; win_first_a = '0;
    for (int i = 0; i < 256; i++) begin
      busy_log_a[i] = 1'bx;
      perf_log_a[i] = -1;
    end
    wr_cnt_b = 0; rd_cnt_b = 0; bad_rd_b = 0; done_cnt_b = 0; done_cyc_b = -1; last_data_b = -1;
    wr_cnt_z = 0; rd_cnt_z = 0; done_cnt_z = 0; done_cyc_z = -1;
  endtask

  // Start pulse issued during relative cycle 0; the first FETCH cycle is relative cycle 1.
  task automatic kick(input bit a, input bit b, input bit z);
    @(posedge clk);
    #1;
    clear_logs();
    t0 = cyc;
    start_a = a; start_b = b; start_z = z;
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0; start_z = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    for (int i = 0; i < 1000 && (cyc - t0) < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame_a(input string tag, input int exp_data);
    check({tag, " wr count"}, 72'(wa_addr.size()), 72'd9);
    for (int i = 0; i < 9 && i < wa_addr.size(); i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), 72'(wa_addr[i]), 72'(i));
      check($sformatf("%s wr_data[%0d]", tag, i), 72'(wa_data[i]), 72'(exp_data));
      check($sformatf("%s wr_cyc[%0d]", tag, i), 72'(wa_cyc[i]), 72'(12 * i + 12));
    end
    check({tag, " done count"}, 72'(done_cnt_a), 72'd1);
    check({tag, " done cycle"}, 72'(done_cyc_a), 72'd109);
    check({tag, " busy c1"}, 72'(busy_log_a[1]), 72'd1);
    check({tag, " busy c109"}, 72'(busy_log_a[109]), 72'd1);
    check({tag, " busy c110"}, 72'(busy_log_a[110]), 72'd0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'(i);
  endtask

  initial begin
    load_ramp();
    clear_logs();

    // Reset state
    #1;
    check("reset busy", 72'(busy_a), 72'd0);
    check("reset done", 72'(done_a), 72'd0);
    check("reset rd_en", 72'(rd_en_a), 72'd0);
    check("reset wr_en", 72'(wr_en_a), 72'd0);
    check("reset win_data", win_data_a, 72'd0);
    check("reset wr_data", 72'(wr_data_a), 72'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Frame 1: ramp image on A, 10x11 on B, empty grid on Z
    kick(1'b1, 1'b1, 1'b1);
    wait_rel(120);
    check_frame_a("ramp", 1);
    check("ramp win cycle", 72'(win_cyc_a), 72'd11);
    check("ramp win0", win_first_a, 72'h14_13_12_0B_0A_09_02_01_00);
    check("b wr count", 72'(wr_cnt_b), 72'd9);
    check("b rd count", 72'(rd_cnt_b), 72'd81);
    check("b bad reads/addrs", 72'(bad_rd_b), 72'd0);
    check("b done count", 72'(done_cnt_b), 72'd1);
    check("b done cycle", 72'(done_cyc_b), 72'd109);
    check("b last data", 72'(last_data_b), 72'd1);
    check("z done count", 72'(done_cnt_z), 72'd1);
    check("z done cycle", 72'(done_cyc_z), 72'd1);
    check("z rd count", 72'(rd_cnt_z), 72'd0);
    check("z wr count", 72'(wr_cnt_z), 72'd0);
`ifdef POOL_PERF_EN
    check("perf c1", 72'(perf_log_a[1]), 72'd0);
    check("perf after done", 72'(perf_log_a[110]), 72'd109);
    check("perf hold", 72'(perf_a), 72'd109);
`endif

    // Frame 2: checkerboard 0/200, start re-asserted while busy
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) mem_a[r*9+c] = ((r + c) % 2) ? 8'd200 : 8'd0;
    kick(1'b1, 1'b0, 1'b0);
    wait_rel(5);
    start_a = 1'b1;
    wait_rel(6);
    start_a = 1'b0;
    wait_rel(50);
    start_a = 1'b1;
    wait_rel(51);
    start_a = 1'b0;
    wait_rel(125);
    check_frame_a("checker", 200);
    check("checker win0", win_first_a, 72'h00_C8_00_C8_00_C8_00_C8_00);
`ifdef POOL_PERF_EN
    check("perf restart c1", 72'(perf_log_a[1]), 72'd0);
    check("perf restart c2", 72'(perf_log_a[2]), 72'd1);
    check("perf restart end", 72'(perf_log_a[120]), 72'd109);
`endif

    // Frame 3: reset dropped mid-FETCH of window 2, then a fresh frame
    load_ramp();
    kick(1'b1, 1'b0, 1'b0);
    wait_rel(30);
    check("pre-reset rd_addr", 72'(rd_addr_a), 72'd17);
    check("pre-reset busy", 72'(busy_a), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", 72'(busy_a), 72'd0);
    check("async rd_en", 72'(rd_en_a), 72'd0);
    check("async rd_addr", 72'(rd_addr_a), 72'd0);
    check("async win_data", win_data_a, 72'd0);
    check("async wr_data", 72'(wr_data_a), 72'd0);
    check("async wr_addr", 72'(wr_addr_a), 72'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    kick(1'b1, 1'b0, 1'b0);
    wait_rel(120);
    check_frame_a("post-reset", 1);
    check("post-reset win0", win_first_a, 72'h14_13_12_0B_0A_09_02_01_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
